regfile: RTL and testbench
==========================

# regfile

Parametrised successor to the core's two-port register file: a multi-read-port, one-write-port register file with registered reads and write-first bypass. It also holds a per-register pending-write scoreboard so the core can stall on in-flight RAM loads. It sits between instruction decode and the ALU/RAM write-back path of `proc`. It fixes the old write-back hazard, where a same-cycle write was lost to the read, and adds reset, write enable and a hardwired zero register.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; AW = clog2(NREGS) is the index width
- NRD, 2, number of read ports
- ZERO_REG, 1, if 1 register 0 always reads 0, is never written and is never busy

Ports (read port k occupies slice [k*AW +: AW] of i_rd_reg and [k*WIDTH +: WIDTH] of o_rd_val):
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_rd_en  in  NRD  per-port read enable
- i_rd_reg  in  NRD*AW  per-port read register index
- o_rd_val  out  NRD*WIDTH  per-port registered read data
- o_rd_busy  out  NRD  per-port registered busy flag of the register read
- i_wb_en  in  1  write-back enable
- i_wb_reg  in  AW  write-back register index
- i_wb_val  in  WIDTH  write-back data
- i_mark_en  in  1  mark a register pending (a load has been issued)
- i_mark_reg  in  AW  register index to mark

## Operation
- Storage: NREGS x WIDTH data array, plus an NREGS-bit busy vector.
- Write: on an edge with i_wb_en=1, regfile[i_wb_reg] <= i_wb_val and busy[i_wb_reg] is cleared.
- Mark: on an edge with i_mark_en=1, busy[i_mark_reg] is set.
- Simultaneous write and mark to the same register: data is written and busy ends at 1. The mark wins because it represents a newer load.
- Read port k, on an edge with i_rd_en[k]=1, selects o_rd_val[k] by the first matching case:
  - if the index is 0 and ZERO_REG=1: 0;
  - else if i_wb_en=1 and i_wb_reg == i_rd_reg[k]: i_wb_val (write-first bypass);
  - else: regfile[i_rd_reg[k]].
- With the same enable, o_rd_busy[k] <= the busy bit of i_rd_reg[k] after this edge's write and mark updates.
- Read port k with i_rd_en[k]=0: o_rd_val[k] and o_rd_busy[k] hold their values.
- Ports are independent. Any number of ports may read the same index in the same cycle.
- ZERO_REG=1: writes and marks to index 0 are ignored. Index 0 reads 0 and not busy.
- Index >= NREGS (NREGS not a power of 2): reads return 0 and not busy. Writes and marks to such an index are ignored.
- Reset (i_rst=0): all registers, all busy bits, o_rd_val and o_rd_busy are cleared to 0 immediately, without waiting for a clock edge. This holds mid-operation.
  - Write, mark and read requests are ignored while i_rst=0.
  - The first rising edge after i_rst returns to 1 operates normally.

## Timing
- Read latency is 1 cycle: index presented before edge N gives data valid after edge N until the next enabled read.
- Write is visible to a read presented at the same edge N (bypass). Every later read returns the new value.
- Mark at edge N: a read of the same register at edge N reports o_rd_busy=1 after N.
- Write at edge N to a busy register: a read at edge N reports busy=0 unless a mark to the same register also occurs at N.
- There is no combinational path from any input to any output.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse i_rst low between clock edges. o_rd_val=0 and o_rd_busy=0 immediately, and a subsequent read of r5 returns 0.
- Write then read: write 0x12345678 to r7 at edge N, read r7 on port 1 at edge N+1. Port 1 shows 0x12345678 after N+1, and port 0 holding with rd_en=0 is unchanged.
- Bypass: write 0xA5A5A5A5 to r3 while both ports read r3 at the same edge. Both ports show 0xA5A5A5A5 after that edge.
- Zero register: write 0xFFFFFFFF to r0 and mark r0, then read r0. Data is 0 and busy is 0. Repeat with ZERO_REG=0: data is 0xFFFFFFFF and busy is 1.
- Scoreboard: mark r9 at edge N, read r9 at N+1 (busy=1), write 0x55 to r9 at N+2 with a same-edge read (data 0x55, busy=0). Then mark and write r9 at the same edge: busy=1.
- Out of range with NREGS=24, NRD=3: write r30 = 0x77, then read r30 on all 3 ports. All ports show 0 and not busy, and r0–r23 are unchanged.

Source files
------------

// File: rtl/regfile.sv
// Multi-read, single-write register file with write-first bypass and per-register load-pending flags.
// Reads are registered (1 cycle). There is no backpressure: every enabled request is serviced on its edge.
module regfile #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NRD-1:0]       i_rd_en,
  input  logic [NRD*AW-1:0]    i_rd_reg,
  output logic [NRD*WIDTH-1:0] o_rd_val,
  output logic [NRD-1:0]       o_rd_busy,
  input  logic                 i_wb_en,
  input  logic [AW-1:0]        i_wb_reg,
  input  logic [WIDTH-1:0]     i_wb_val,
  input  logic                 i_mark_en,
  input  logic [AW-1:0]        i_mark_reg
);

  logic [WIDTH-1:0]     mem [NREGS];
  logic [NREGS-1:0]     busy;
  logic [NREGS-1:0]     busy_nxt;
  logic                 wb_ok;
  logic                 mark_ok;
  logic [NRD*WIDTH-1:0] rd_val_nxt;
  logic [NRD-1:0]       rd_busy_nxt;
  logic [AW-1:0]        idx;

  // An index is storable only if it exists and is not the hardwired zero register.
  function automatic logic valid_idx(input logic [AW-1:0] r);
    return (32'(r) < NREGS) && !(ZERO_REG && (r == '0));
  endfunction

  assign wb_ok   = i_wb_en && valid_idx(i_wb_reg);
  assign mark_ok = i_mark_en && valid_idx(i_mark_reg);

  // Mark is applied after the write clear: a newer load outranks the returning one.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok) begin
      busy_nxt[i_wb_reg] = 1'b0;
    end
    if (mark_ok) begin
      busy_nxt[i_mark_reg] = 1'b1;
    end
  end

  always_comb begin
    rd_val_nxt  = o_rd_val;
    rd_busy_nxt = o_rd_busy;
    idx         = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = i_rd_reg[k*AW +: AW];
      if (i_rd_en[k]) begin
        if (!valid_idx(idx)) begin
          rd_val_nxt[k*WIDTH +: WIDTH] = '0;
          rd_busy_nxt[k]               = 1'b0;
        end else if (wb_ok && (i_wb_reg == idx)) begin
          rd_val_nxt[k*WIDTH +: WIDTH] = i_wb_val;
          rd_busy_nxt[k]               = busy_nxt[idx];
        end else begin
          rd_val_nxt[k*WIDTH +: WIDTH] = mem[idx];
          rd_busy_nxt[k]               = busy_nxt[idx];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_ok) begin
      mem[i_wb_reg] <= i_wb_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy      <= '0;
      o_rd_val  <= '0;
      o_rd_busy <= '0;
    end else begin
      busy      <= busy_nxt;
      o_rd_val  <= rd_val_nxt;
      o_rd_busy <= rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: three configurations (default, ZERO_REG=0, NREGS=24/NRD=3) checked through per-instance expectation queues.
module tb_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  a_rd_en;  logic [9:0]  a_rd_reg;  logic [63:0] a_rd_val;  logic [1:0] a_rd_busy;
  logic        a_wb_en;  logic [4:0]  a_wb_reg;  logic [31:0] a_wb_val;  logic a_mark_en; logic [4:0] a_mark_reg;
  logic [1:0]  b_rd_en;  logic [9:0]  b_rd_reg;  logic [63:0] b_rd_val;  logic [1:0] b_rd_busy;
  logic        b_wb_en;  logic [4:0]  b_wb_reg;  logic [31:0] b_wb_val;  logic b_mark_en; logic [4:0] b_mark_reg;
  logic [2:0]  c_rd_en;  logic [14:0] c_rd_reg;  logic [95:0] c_rd_val;  logic [2:0] c_rd_busy;
  logic        c_wb_en;  logic [4:0]  c_wb_reg;  logic [31:0] c_wb_val;  logic c_mark_en; logic [4:0] c_mark_reg;

  regfile #(.WIDTH(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rd_en(a_rd_en), .i_rd_reg(a_rd_reg), .o_rd_val(a_rd_val),
    .o_rd_busy(a_rd_busy), .i_wb_en(a_wb_en), .i_wb_reg(a_wb_reg), .i_wb_val(a_wb_val),
    .i_mark_en(a_mark_en), .i_mark_reg(a_mark_reg));

  regfile #(.WIDTH(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rd_en(b_rd_en), .i_rd_reg(b_rd_reg), .o_rd_val(b_rd_val),
    .o_rd_busy(b_rd_busy), .i_wb_en(b_wb_en), .i_wb_reg(b_wb_reg), .i_wb_val(b_wb_val),
    .i_mark_en(b_mark_en), .i_mark_reg(b_mark_reg));

  regfile #(.WIDTH(32), .NREGS(24), .NRD(3), .ZERO_REG(1'b1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_rd_en(c_rd_en), .i_rd_reg(c_rd_reg), .o_rd_val(c_rd_val),
    .o_rd_busy(c_rd_busy), .i_wb_en(c_wb_en), .i_wb_reg(c_wb_reg), .i_wb_val(c_wb_val),
    .i_mark_en(c_mark_en), .i_mark_reg(c_mark_reg));

  typedef struct {
    string       name;
    logic [31:0] val;
    logic        busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic no_exp(input string dut, input int p);
    checks++;
    failures++;
    $display("FAIL %s_unexpected_read: port %0d produced data with nothing queued", dut, p);
  endtask

  // Monitor: every port enabled at an edge presents a result that must match the queue head.
  initial begin
    logic [1:0] ea;
    logic [1:0] eb;
    logic [2:0] ec;
    logic       rs;
    exp_t       e;
    forever begin
      @(posedge clk);
      ea = a_rd_en; eb = b_rd_en; ec = c_rd_en; rs = rst;
      #2;
      if (rs) begin
        for (int p = 0; p < 2; p++) if (ea[p]) begin
          if (qa.size() == 0) no_exp("a", p);
          else begin
            e = qa.pop_front();
            chk({e.name, "_val"}, a_rd_val[p*32 +: 32], e.val);
            chk({e.name, "_busy"}, {31'b0, a_rd_busy[p]}, {31'b0, e.busy});
          end
        end
        for (int p = 0; p < 2; p++) if (eb[p]) begin
          if (qb.size() == 0) no_exp("b", p);
          else begin
            e = qb.pop_front();
            chk({e.name, "_val"}, b_rd_val[p*32 +: 32], e.val);
            chk({e.name, "_busy"}, {31'b0, b_rd_busy[p]}, {31'b0, e.busy});
          end
        end
        for (int p = 0; p < 3; p++) if (ec[p]) begin
          if (qc.size() == 0) no_exp("c", p);
          else begin
            e = qc.pop_front();
            chk({e.name, "_val"}, c_rd_val[p*32 +: 32], e.val);
            chk({e.name, "_busy"}, {31'b0, c_rd_busy[p]}, {31'b0, e.busy});
          end
        end
      end
    end
  end

  task automatic idle();
    a_rd_en = '0; a_wb_en = 1'b0; a_mark_en = 1'b0;
    b_rd_en = '0; b_wb_en = 1'b0; b_mark_en = 1'b0;
    c_rd_en = '0; c_wb_en = 1'b0; c_mark_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read requests must be issued in ascending port order within a cycle.
  task automatic rd_a(input int p, input logic [4:0] r, input logic [31:0] v, input logic b, input string n);
    exp_t e;
    a_rd_en[p] = 1'b1; a_rd_reg[p*5 +: 5] = r;
    e.name = n; e.val = v; e.busy = b; qa.push_back(e);
  endtask
  task automatic rd_b(input int p, input logic [4:0] r, input logic [31:0] v, input logic b, input string n);
    exp_t e;
    b_rd_en[p] = 1'b1; b_rd_reg[p*5 +: 5] = r;
    e.name = n; e.val = v; e.busy = b; qb.push_back(e);
  endtask
  task automatic rd_c(input int p, input logic [4:0] r, input logic [31:0] v, input logic b, input string n);
    exp_t e;
    c_rd_en[p] = 1'b1; c_rd_reg[p*5 +: 5] = r;
    e.name = n; e.val = v; e.busy = b; qc.push_back(e);
  endtask

  task automatic wb_a(input logic [4:0] r, input logic [31:0] v); a_wb_en = 1'b1; a_wb_reg = r; a_wb_val = v; endtask
  task automatic wb_b(input logic [4:0] r, input logic [31:0] v); b_wb_en = 1'b1; b_wb_reg = r; b_wb_val = v; endtask
  task automatic wb_c(input logic [4:0] r, input logic [31:0] v); c_wb_en = 1'b1; c_wb_reg = r; c_wb_val = v; endtask
  task automatic mark_a(input logic [4:0] r); a_mark_en = 1'b1; a_mark_reg = r; endtask
  task automatic mark_b(input logic [4:0] r); b_mark_en = 1'b1; b_mark_reg = r; endtask
  task automatic mark_c(input logic [4:0] r); c_mark_en = 1'b1; c_mark_reg = r; endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    a_rd_reg = '0; a_wb_reg = '0; a_wb_val = '0; a_mark_reg = '0;
    b_rd_reg = '0; b_wb_reg = '0; b_wb_val = '0; b_mark_reg = '0;
    c_rd_reg = '0; c_wb_reg = '0; c_wb_val = '0; c_mark_reg = '0;
    #12;
    chk("reset_a_val", {31'b0, |a_rd_val}, 32'd0);
    chk("reset_c_busy", {29'b0, c_rd_busy}, 32'd0);
    rst = 1'b1;
    step();

    // Asynchronous reset in the middle of operation.
    idle(); wb_a(5, 32'hDEADBEEF); mark_a(6); step();
    idle(); rd_a(0, 5, 32'hDEADBEEF, 1'b0, "t1_pre_r5"); rd_a(1, 6, 32'h0, 1'b1, "t1_pre_r6"); step();
    idle();
    #3; rst = 1'b0;
    #1;
    chk("t1_async_val", {31'b0, |a_rd_val}, 32'd0);
    chk("t1_async_busy", {30'b0, a_rd_busy}, 32'd0);
    #2; rst = 1'b1;
    step();
    idle(); rd_a(0, 5, 32'h0, 1'b0, "t1_post_r5"); rd_a(1, 6, 32'h0, 1'b0, "t1_post_r6"); step();

    // Write then read; a disabled port holds even when its index changes.
    idle(); wb_a(8, 32'h0BADF00D); step();
    idle(); wb_a(7, 32'h12345678); rd_a(0, 7, 32'h12345678, 1'b0, "t2_p0_r7"); step();
    idle(); a_rd_reg[4:0] = 5'd8; rd_a(1, 7, 32'h12345678, 1'b0, "t2_p1_r7"); step();
    chk("t2_p0_hold_val", a_rd_val[31:0], 32'h12345678);
    chk("t2_p0_hold_busy", {31'b0, a_rd_busy[0]}, 32'd0);

    // Same-edge write bypass to both ports.
    idle(); wb_a(3, 32'hA5A5A5A5);
    rd_a(0, 3, 32'hA5A5A5A5, 1'b0, "t3_p0"); rd_a(1, 3, 32'hA5A5A5A5, 1'b0, "t3_p1"); step();

    // Register 0: hardwired in u_a, ordinary in u_b.
    idle();
    wb_a(0, 32'hFFFFFFFF); mark_a(0); rd_a(1, 0, 32'h0, 1'b0, "t4a_same");
    wb_b(0, 32'hFFFFFFFF); mark_b(0); rd_b(1, 0, 32'hFFFFFFFF, 1'b1, "t4b_same");
    step();
    idle();
    rd_a(0, 0, 32'h0, 1'b0, "t4a_p0"); rd_a(1, 0, 32'h0, 1'b0, "t4a_p1");
    rd_b(0, 0, 32'hFFFFFFFF, 1'b1, "t4b_p0");
    step();

    // Pending-load scoreboard.
    idle(); mark_a(9); rd_a(1, 9, 32'h0, 1'b1, "t5_mark_same"); step();
    idle(); rd_a(0, 9, 32'h0, 1'b1, "t5_busy"); step();
    idle(); wb_a(9, 32'h55); rd_a(0, 9, 32'h55, 1'b0, "t5_wb_clear"); step();
    idle(); wb_a(9, 32'h66); mark_a(9); rd_a(1, 9, 32'h66, 1'b1, "t5_mark_wins"); step();
    idle(); rd_a(0, 9, 32'h66, 1'b1, "t5_persist"); step();

    // Out-of-range index on the 24-entry, 3-port instance.
    idle(); wb_c(23, 32'h2323); step();
    idle(); wb_c(1, 32'h11); step();
    idle();
    rd_c(0, 23, 32'h2323, 1'b0, "t6_pre0"); rd_c(1, 23, 32'h2323, 1'b0, "t6_pre1");
    rd_c(2, 1, 32'h11, 1'b0, "t6_pre2");
    step();
    idle(); wb_c(30, 32'h77); mark_c(30);
    rd_c(0, 30, 32'h0, 1'b0, "t6_same0"); rd_c(1, 30, 32'h0, 1'b0, "t6_same1"); rd_c(2, 30, 32'h0, 1'b0, "t6_same2");
    step();
    idle();
    rd_c(0, 30, 32'h0, 1'b0, "t6_after0"); rd_c(1, 30, 32'h0, 1'b0, "t6_after1"); rd_c(2, 30, 32'h0, 1'b0, "t6_after2");
    step();
    idle();
    rd_c(0, 23, 32'h2323, 1'b0, "t6_r23"); rd_c(1, 1, 32'h11, 1'b0, "t6_r1"); rd_c(2, 22, 32'h0, 1'b0, "t6_r22");
    step();

    idle();
    step();
    step();
    chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
